alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and issue controller that shares one `WIDTH`-bit ALU (AND/OR/XOR/ADD, 2-bit opcode) between `NUM_REQ` requesters in the AES datapath.
- Each requester presents an opcode and two operands over a valid/ready handshake.
- The block grants one requester per cycle, drives the internal ALU and captures the result in a single-entry response register.
- The response register returns result, zero flag and requester ID over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 4, operand/result width in bits (≥1)
- `NUM_REQ`, 4, number of requesters (2..8)
- `IDW`, `$clog2(NUM_REQ)`, requester ID width (derived; do not override)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  `NUM_REQ`  bit i: requester i has an operation pending
- `req_ready`  out  `NUM_REQ`  bit i: requester i accepted this cycle (one-hot or zero)
- `req_op`  in  `2*NUM_REQ`  opcode of requester i at bits [2i+1:2i]; 00 AND, 01 OR, 10 XOR, 11 ADD
- `req_a`  in  `WIDTH*NUM_REQ`  operand A of requester i at slice i
- `req_b`  in  `WIDTH*NUM_REQ`  operand B of requester i at slice i
- `rsp_valid`  out  1  response register holds a result
- `rsp_ready`  in  1  consumer takes the response this cycle
- `rsp_id`  out  `IDW`  index of the requester that owns the response
- `rsp_result`  out  `WIDTH`  ALU result
- `rsp_zero`  out  1  1 when `rsp_result` is all zeros
- `busy`  out  1  equals `rsp_valid`
- `req_lock`  in  `NUM_REQ`  present only with `ALU_ARB_LOCK_EN`; see Configuration

## Operation
- State machine with two states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- Issue window (`can_issue`): EMPTY, or FULL with `rsp_ready`=1.
  - In FULL, the drain and the new issue happen in the same cycle.
- Arbitration:
  - Round-robin search starts at index `last_grant+1` and wraps after `NUM_REQ-1`.
  - The winner is the first i with `req_valid[i]`=1.
  - `req_ready[winner]`=1 only when `can_issue`; all other bits are 0.
  - `req_ready` depends combinationally on `req_valid` and `rsp_ready`.
- On accept, at the next edge:
  - `rsp_result` ← ALU(op, a, b).
  - `rsp_zero` ← (result == 0).
  - `rsp_id` ← winner.
  - `last_grant` ← winner.
  - State → FULL.
- Drain with no accept: state → EMPTY. `rsp_result`, `rsp_zero` and `rsp_id` keep their last values.
- Arithmetic:
  - ADD wraps modulo 2^WIDTH; the carry is discarded.
  - Logic ops are bitwise over the full `WIDTH`.
  - Any opcode value is legal.
- Stability:
  - While FULL and `rsp_ready`=0, all `rsp_*` outputs hold stable and `req_ready` is all zeros.
  - Requesters hold `req_valid` and payload stable until accepted.
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0, `busy`=0.
  - Internal `last_grant`=`NUM_REQ-1`, so requester 0 wins first.
- Reset mid-operation: any pending response is discarded. `req_ready` is 0 during the cycle `rst`=1.

## Timing
- Latency: accept in cycle N → `rsp_valid`=1 with data in cycle N+1.
- Throughput: one operation per cycle while `rsp_ready` is held at 1.
- `rsp_valid` never depends combinationally on `rsp_ready`.
- No requester waits more than `NUM_REQ-1` grants once valid (lock disabled).

## Configuration
- Macro: `ALU_ARB_LOCK_EN`.
- Defined:
  - Adds the `req_lock` input.
  - If requester `last_grant` has `req_valid`=1 and `req_lock`=1 in an issue window, it wins regardless of rotation.
  - This allows back-to-back multi-word sequences, e.g. 128-bit XOR over 32 nibbles.
  - When lock drops, rotation resumes at `last_grant+1`.
- Undefined:
  - `req_lock` port is absent.
  - Pure round-robin as described above.

## Test plan
All scenarios use `WIDTH`=4, `NUM_REQ`=4.
- **Add with wrap:** reset, then req0 op=11 a=4'h9 b=4'h8 → `req_ready`=4'b0001 same cycle; next cycle `rsp_valid`=1, `rsp_result`=4'h1, `rsp_zero`=0, `rsp_id`=0.
- **Rotation:** all four `req_valid`=1 continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,1 on consecutive cycles, one response per cycle.
- **Backpressure:** response held with `rsp_ready`=0 for 3 cycles → `req_ready`=0 and all `rsp_*` outputs stable; `rsp_ready`=1 → the next requester is accepted in the same cycle and its response appears the following cycle.
- **Zero flag:** req1 op=10 a=4'hA b=4'hA → `rsp_result`=4'h0, `rsp_zero`=1, `rsp_id`=1; then op=01 a=4'h0 b=4'h0 → `rsp_zero`=1.
- **Reset mid-operation:** assert `rst` for 1 cycle while `rsp_valid`=1 and last grant was 2 → next cycle `rsp_valid`=0, `rsp_result`=0; with all requesting, the first response after reset has `rsp_id`=0.
- **Lock (macro defined):** req2 wins with `req_lock[2]`=1 while req1 and req3 stay valid → req2 wins 3 consecutive cycles; `req_lock[2]`=0 → next grant goes to req3. Macro undefined → grants rotate 2,3,0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter issuing requests to one shared ALU
//
// Purpose: shares one WIDTH-bit ALU (AND/OR/XOR/ADD) between NUM_REQ
// requesters. It grants at most one requester per cycle and captures the
// result in a single-entry response register.
// Optional feature: define ALU_ARB_LOCK_EN to add req_lock. With req_lock,
// the last winner can keep the grant for back-to-back sequences.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready per-requester handshake (ready is one-hot or zero)
//   req_op/a/b      packed per-requester opcode and operands
//   req_lock        per-requester grant lock (ALU_ARB_LOCK_EN only)
//   rsp_valid/ready response handshake
//   rsp_id          owner of the response
//   rsp_result      ALU result
//   rsp_zero        result is all zeros
//   busy            mirrors rsp_valid
module alu_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic                     busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             can_issue;
  logic             found;
  logic             accept;
  logic [IDW-1:0]   winner;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, alu_res;

  // Index base+k, wrapped into 0..NUM_REQ-1. This stays correct when
  // NUM_REQ is not a power of two.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                              input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Search order is last_grant+1 ... last_grant. The last grantee is
  // therefore considered last.
  always_comb begin
    found  = 1'b0;
    winner = last_grant_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[rr_index(last_grant_q, k)]) begin
        found  = 1'b1;
        winner = rr_index(last_grant_q, k);
      end
    end
`ifdef ALU_ARB_LOCK_EN
    if (req_valid[last_grant_q] && req_lock[last_grant_q]) begin
      found  = 1'b1;
      winner = last_grant_q;
    end
`endif
  end

  // Draining and issuing share a cycle when FULL. Holding grants during
  // reset keeps requesters from believing an accept happened.
  assign can_issue = !rst && ((state_q == EMPTY) || rsp_ready);
  assign accept    = can_issue && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    sel_op = req_op[2*int'(winner) +: 2];
    sel_a  = req_a[WIDTH*int'(winner) +: WIDTH];
    sel_b  = req_b[WIDTH*int'(winner) +: WIDTH];
    case (sel_op)
      2'b00:   alu_res = sel_a & sel_b;
      2'b01:   alu_res = sel_a | sel_b;
      2'b10:   alu_res = sel_a ^ sel_b;
      default: alu_res = sel_a + sel_b;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    result_d     = result_q;
    zero_d       = zero_q;
    if (accept) begin
      state_d      = FULL;
      last_grant_d = winner;
      id_d         = winner;
      result_d     = alu_res;
      zero_d       = (alu_res == '0);
    end else if ((state_q == FULL) && rsp_ready) begin
      // The payload is left as-is; only the valid state drops.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= IDW'(NUM_REQ - 1);
      id_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign busy       = rsp_valid;
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter
module tb_alu_arbiter;
  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
`ifdef ALU_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock;
`endif
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_zero;
  logic                     busy;

  alu_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef ALU_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] res;
    logic       z;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_last = NUM_REQ - 1;
  logic model_full = 1'b0;
  logic [WIDTH-1:0] hold_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return 4'(a + b);
    endcase
  endfunction

  function automatic int model_grant();
    if (rst) return -1;
    if (model_full && !rsp_ready) return -1;
`ifdef ALU_ARB_LOCK_EN
    if (req_valid[model_last] && req_lock[model_last]) return model_last;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (model_last + k) % NUM_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    req_op[2*i +: 2]     = op;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  // One clock: check handshake and response against the model mid-cycle,
  // then advance the model and let the edge happen.
  task automatic step();
    int   g;
    rsp_t e;
    logic [NUM_REQ-1:0] exp_rdy;
    @(negedge clk);
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(model_full));
    check("busy", 32'(busy), 32'(model_full));
    if (rsp_valid) begin
      check("rsp_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_result", 32'(rsp_result), 32'(e.res));
        check("rsp_zero", 32'(rsp_zero), 32'(e.z));
        if (rsp_ready && !rst) void'(exp_q.pop_front());
      end
    end
    if (rst) begin
      exp_q.delete();
      model_full = 1'b0;
      model_last = NUM_REQ - 1;
    end else if (g >= 0) begin
      e.id  = g;
      e.res = alu(req_op[2*g +: 2], req_a[WIDTH*g +: WIDTH], req_b[WIDTH*g +: WIDTH]);
      e.z   = (e.res == 4'h0);
      exp_q.push_back(e);
      model_full = 1'b1;
      model_last = g;
    end else if (model_full && rsp_ready) begin
      model_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rot_exp[6];
    int lock_exp[4];
    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif
    step();
    step();
    rst = 1'b0;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_result", 32'(rsp_result), 32'd0);
    check("reset_rsp_zero", 32'(rsp_zero), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Add with wrap: 9 + 8 = 0x11 -> 0x1
    set_req(0, 2'b11, 4'h9, 4'h8);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    check("add_valid", 32'(rsp_valid), 32'd1);
    check("add_result", 32'(rsp_result), 32'h1);
    check("add_zero", 32'(rsp_zero), 32'd0);
    check("add_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    step();
    check("drain_valid", 32'(rsp_valid), 32'd0);
    check("drain_keeps_result", 32'(rsp_result), 32'h1);

    // Rotation from reset with all requesters valid
    rsp_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    rot_exp = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      step();
      check("rotation_id", 32'(rsp_id), 32'(rot_exp[i]));
      check("rotation_valid", 32'(rsp_valid), 32'd1);
    end
    req_valid = '0;
    step();

    // Backpressure: accept req2, then hold the response for 3 cycles
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    step();
    check("bp_id", 32'(rsp_id), 32'd2);
    hold_res = rsp_result;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_id", 32'(rsp_id), 32'd2);
      check("bp_hold_result", 32'(rsp_result), 32'(hold_res));
    end
    rsp_ready = 1'b1;
    step();
    check("bp_release_id", 32'(rsp_id), 32'd3);
    check("bp_release_valid", 32'(rsp_valid), 32'd1);
    req_valid = '0;
    step();

    // Zero flag
    set_req(1, 2'b10, 4'hA, 4'hA);
    req_valid = 4'b0010;
    step();
    check("zero_xor_result", 32'(rsp_result), 32'h0);
    check("zero_xor_flag", 32'(rsp_zero), 32'd1);
    check("zero_xor_id", 32'(rsp_id), 32'd1);
    set_req(1, 2'b01, 4'h0, 4'h0);
    step();
    check("zero_or_flag", 32'(rsp_zero), 32'd1);
    set_req(1, 2'b00, 4'hF, 4'h6);
    step();
    check("and_result", 32'(rsp_result), 32'h6);
    check("and_zero", 32'(rsp_zero), 32'd0);
    req_valid = '0;
    step();

    // Reset mid-operation right after req2 was granted
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 2'b11, 4'(i + 1), 4'h3);
    req_valid = 4'b1111;
    step();
    check("pre_reset_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_reset_valid", 32'(rsp_valid), 32'd0);
    check("post_reset_result", 32'(rsp_result), 32'd0);
    rsp_ready = 1'b1;
    step();
    check("post_reset_first_id", 32'(rsp_id), 32'd0);

    // Lock: req1 then req2 by rotation; req2 holds its lock for 3 grants
    step();
    check("lock_pre_id", 32'(rsp_id), 32'd1);
`ifdef ALU_ARB_LOCK_EN
    req_lock = 4'b0100;
    lock_exp = '{2, 2, 2, 3};
`else
    lock_exp = '{2, 3, 0, 1};
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      check("lock_id", 32'(rsp_id), 32'(lock_exp[i]));
    end
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif
    step();
    check("lock_release_id", 32'(rsp_id), 32'(lock_exp[3]));
    req_valid = '0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
